// File: rtl/kpn_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// kpn_fifo_write_arbiter
//
// Shares the single write port of one KPN channel FIFO between N_REQ producer
// processes. Grants rotate round-robin, and each grant may carry a burst of up
// to MAX_BURST words. The FIFO has no full flag, so this block keeps a shadow
// occupancy counter. Its own writes increment the counter, and the consumer's
// snooped read strobe decrements it.
//
// Optional feature: define KPN_ARB_STATS_EN to add the stall_cnt output. It
// is a saturating 16-bit count of the cycles where some requester was waiting
// while the FIFO was full.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req         in   [N_REQ] per-requester request; data valid while high
//   data_in     in   [N_REQ*BITS_NUMBER] packed tokens, requester i at
//                    [i*BITS_NUMBER +: BITS_NUMBER]
//   ack         out  [N_REQ] one-hot, combinational; word taken at this edge
//   fifo_rd     in   snooped consumer read strobe
//   fifo_wr     out  registered FIFO write strobe
//   fifo_data   out  [BITS_NUMBER] registered token for FIFO entry_1
//   fifo_full   out  registered, occupancy == 2**FIFO_ELEMENTS
//   fifo_empty  out  registered, occupancy == 0
//   stall_cnt   out  [16] stall cycle counter (KPN_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module kpn_fifo_write_arbiter #(
    parameter int BITS_NUMBER   = 16,
    parameter int FIFO_ELEMENTS = 5,
    parameter int N_REQ         = 4,
    parameter int MAX_BURST     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*BITS_NUMBER-1:0]  data_in,
    output logic [N_REQ-1:0]              ack,
    input  logic                          fifo_rd,
    output logic                          fifo_wr,
    output logic [BITS_NUMBER-1:0]        fifo_data,
    output logic                          fifo_full,
    output logic                          fifo_empty
`ifdef KPN_ARB_STATS_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OCC_W = FIFO_ELEMENTS + 1;
    localparam int CNT_W = 4;

    localparam logic [OCC_W-1:0] DEPTH    = OCC_W'(1) << FIFO_ELEMENTS;
    localparam logic [CNT_W-1:0] MAX_B    = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W + 1)'(N_REQ);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic                    fifo_wr_q;
    logic [BITS_NUMBER-1:0]  fifo_data_q, fifo_data_d;
    logic                    full_q, empty_q;

    logic                    has_room;
    logic                    issue;
    logic                    dec;
    logic [IDX_W-1:0]        grant_idx;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // Occupancy never exceeds DEPTH, so "not equal" is "below DEPTH".
    assign has_room = (occ_q != DEPTH);

    // Round-robin search: rotate req so that bit 0 is rr_ptr, and take the
    // lowest set bit. Then map the offset back to an absolute index.
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   rot_off;
    logic               rot_vld;
    logic [IDX_W:0]     pick_sum;
    logic [IDX_W-1:0]   pick;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[rr_ptr_q +: N_REQ];

    always_comb begin
        rot_off = '0;
        rot_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rot_off = IDX_W'(k);
                rot_vld = 1'b1;
            end
        end
    end

    always_comb begin
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, rot_off};
        if (pick_sum >= N_REQ_W) begin
            pick_sum = pick_sum - N_REQ_W;
        end
        pick = pick_sum[IDX_W-1:0];
    end

    // Arbitration FSM, next-state and grant
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        issue       = 1'b0;
        grant_idx   = owner_q;
        case (state_q)
            S_IDLE: begin
                if (rot_vld && has_room) begin
                    issue       = 1'b1;
                    grant_idx   = pick;
                    owner_d     = pick;
                    burst_cnt_d = CNT_W'(1);
                    if (MAX_BURST > 1) begin
                        state_d = S_BURST;
                    end else begin
                        rr_ptr_d = wrap_inc(pick);
                    end
                end
            end
            S_BURST: begin
                if (req[owner_q] && (burst_cnt_q < MAX_B)) begin
                    // While full, hold the grant and freeze the count.
                    if (has_room) begin
                        issue       = 1'b1;
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end else begin
                    // The burst ends in this cycle. The next grant is made in
                    // the IDLE cycle that follows.
                    rr_ptr_d = wrap_inc(owner_q);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // ack is combinational, so it must also fall as soon as reset asserts.
        if (!rst_n) begin
            issue = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
            assign ack[gi] = issue && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    // A read takes a word only if one exists, counting the word being
    // written in this cycle. This stops the counter from underflowing.
    assign dec   = fifo_rd && ((occ_q != '0) || issue);
    assign occ_d = occ_q + {{(OCC_W-1){1'b0}}, issue} - {{(OCC_W-1){1'b0}}, dec};

    assign fifo_data_d = issue ? data_in[grant_idx*BITS_NUMBER +: BITS_NUMBER] : fifo_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            occ_q       <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            occ_q       <= occ_d;
            fifo_wr_q   <= issue;
            fifo_data_q <= fifo_data_d;
            full_q      <= (occ_d == DEPTH);
            empty_q     <= (occ_d == '0);
        end
    end

    assign fifo_wr    = fifo_wr_q;
    assign fifo_data  = fifo_data_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;

`ifdef KPN_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // A waiting requester with no room available counts as a stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|req) && !has_room && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_kpn_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for kpn_fifo_write_arbiter. It runs directed scenarios first and
// randomized traffic after them. A reference model kept in plain integers
// predicts ack, fifo_wr/fifo_data, the full/empty flags and the optional
// stall counter (KPN_ARB_STATS_EN).
// ---------------------------------------------------------------------------
module tb_kpn_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int B     = 16;
    localparam int FE    = 5;
    localparam int MAXB  = 4;
    localparam int DEPTH = 1 << FE;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*B-1:0]   data_in;
    logic [N-1:0]     ack;
    logic             fifo_rd;
    logic             fifo_wr;
    logic [B-1:0]     fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
`ifdef KPN_ARB_STATS_EN
    logic [15:0]      stall_cnt;
`endif

    kpn_fifo_write_arbiter #(
        .BITS_NUMBER   (B),
        .FIFO_ELEMENTS (FE),
        .N_REQ         (N),
        .MAX_BURST     (MAXB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .fifo_rd    (fifo_rd),
        .fifo_wr    (fifo_wr),
        .fifo_data  (fifo_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
`ifdef KPN_ARB_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc;

    // Requester-side stimulus state
    logic [N-1:0]   rq;
    logic [N*B-1:0] dat;
    logic [N-1:0]   last_ack;

    // Reference model. m_cur is the requester that holds the port, or -1 when
    // the next cycle is an arbitration cycle.
    int             m_cur, m_cnt, m_ptr, m_occ, m_stall;
    logic           m_wr;
    logic [B-1:0]   m_wdata;

    logic [N-1:0] grant_tbl [0:19] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd0,
                                       4'd2, 4'd2, 4'd2, 4'd2, 4'd0,
                                       4'd4, 4'd4, 4'd4, 4'd4, 4'd0,
                                       4'd8, 4'd8, 4'd8, 4'd8, 4'd0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cur = -1; m_cnt = 0; m_ptr = 0; m_occ = 0; m_stall = 0;
        m_wr = 1'b0; m_wdata = '0; last_ack = '0;
    endtask

    // Holds rst_n low for two edges, checks the reset values, and then
    // releases rst_n one time unit after an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        check_eq("rst_fifo_data", 32'(fifo_data), 32'd0);
        check_eq("rst_fifo_full", 32'(fifo_full), 32'd0);
        check_eq("rst_fifo_empty", 32'(fifo_empty), 32'd1);
`ifdef KPN_ARB_STATS_EN
        check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        rst_n = 1'b1;
    endtask

    // One clock cycle. The task is entered 1 time unit after a rising edge.
    // It drives the inputs, predicts the outputs, checks them before the next
    // edge, and then advances the model across that edge.
    task automatic step(input logic rd_in, output logic [N-1:0] got_ack);
        logic [N-1:0] eack;
        int g, n_cur, n_cnt, n_ptr;
        bit room;
        req     = rq;
        data_in = dat;
        fifo_rd = rd_in;

        eack = '0; g = -1;
        n_cur = m_cur; n_cnt = m_cnt; n_ptr = m_ptr;
        room = (m_occ < DEPTH);
        if (m_cur < 0) begin
            if (rq != '0 && room) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (g < 0 && rq[idx]) g = idx;
                end
                n_cnt = 1;
                if (MAXB > 1) n_cur = g;
                else          n_ptr = (g + 1) % N;
            end
        end else if (rq[m_cur] && m_cnt < MAXB) begin
            if (room) begin
                g = m_cur;
                n_cnt = m_cnt + 1;
            end
        end else begin
            n_ptr = (m_cur + 1) % N;
            n_cur = -1;
        end
        if (g >= 0) eack[g] = 1'b1;

        #3;
        got_ack = ack;
        check_eq("ack", 32'(ack), 32'(eack));
        check_eq("fifo_wr", 32'(fifo_wr), 32'(m_wr));
        if (m_wr) check_eq("fifo_data", 32'(fifo_data), 32'(m_wdata));
        check_eq("fifo_full", 32'(fifo_full), 32'(m_occ == DEPTH));
        check_eq("fifo_empty", 32'(fifo_empty), 32'(m_occ == 0));
`ifdef KPN_ARB_STATS_EN
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        $display("cyc %0d req=%b rd=%b ack=%b wr=%b data=%h occ=%0d",
                 cyc, rq, rd_in, ack, fifo_wr, fifo_data, m_occ);

        if (rq != '0 && m_occ == DEPTH && m_stall < 65535) m_stall++;
        if (g >= 0) begin
            m_occ++;
            m_wdata = dat[g*B +: B];
        end
        if (rd_in && m_occ > 0) m_occ--;
        m_wr     = (g >= 0);
        last_ack = eack;
        m_cur = n_cur; m_cnt = n_cnt; m_ptr = n_ptr;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Requesters that were just acked present a fresh token and keep requesting.
    task automatic refresh_acked();
        for (int i = 0; i < N; i++) begin
            if (last_ack[i]) dat[i*B +: B] = 16'($urandom);
        end
    endtask

    // Random protocol-respecting requesters: hold req and data until acked.
    task automatic rand_stim();
        for (int i = 0; i < N; i++) begin
            if (rq[i] && last_ack[i]) begin
                rq[i] = ($urandom_range(0, 2) != 0);
                dat[i*B +: B] = 16'($urandom);
            end else if (!rq[i]) begin
                rq[i] = ($urandom_range(0, 3) == 0);
                if (rq[i]) dat[i*B +: B] = 16'($urandom);
            end
        end
    endtask

    initial begin
        logic [N-1:0] a;
        int thr;
        n_checks = 0; n_errors = 0; cyc = 0;
        rst_n = 1'b0; req = '0; data_in = '0; fifo_rd = 1'b0;
        rq = '0; dat = '0;
        model_reset();

        // Three words from requester 0, no reads
        do_reset();
        rq = 4'b0001; dat[15:0] = 16'hA001;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, a);
            check_eq("t1_ack0", 32'(a), 32'd1);
        end
        rq = '0;
        for (int k = 0; k < 3; k++) step(1'b0, a);
        check_eq("t1_not_empty", 32'(fifo_empty), 32'd0);

        // All requesting, reads every cycle: bursts of 4 with one gap
        do_reset();
        rq = 4'b1111;
        for (int i = 0; i < N; i++) dat[i*B +: B] = 16'($urandom);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, a);
            check_eq("t2_grant", 32'(a), 32'(grant_tbl[k]));
            refresh_acked();
        end

        // Fill to full, then the full and read interactions
        do_reset();
        rq = 4'b0001; dat[15:0] = 16'h0100;
        for (int k = 0; k < 45; k++) begin
            step(1'b0, a);
            refresh_acked();
        end
        check_eq("t3_full", 32'(fifo_full), 32'd1);
        step(1'b0, a);
        check_eq("t3_noack_full", 32'(a), 32'd0);
        step(1'b1, a);
        check_eq("t3_noack_full_rd", 32'(a), 32'd0);
        step(1'b0, a);
        check_eq("t3_ack_after_rd", 32'(a), 32'd1);
        refresh_acked();
        for (int k = 0; k < 5; k++) step(1'b0, a);

        // Reads on an empty FIFO do not underflow
        do_reset();
        rq = '0;
        for (int k = 0; k < 3; k++) step(1'b1, a);
        check_eq("t5_empty", 32'(fifo_empty), 32'd1);

        // Reset in the middle of a burst
        do_reset();
        rq = 4'b1111;
        for (int i = 0; i < N; i++) dat[i*B +: B] = 16'($urandom);
        step(1'b0, a); refresh_acked();
        step(1'b0, a); refresh_acked();
        req = rq; data_in = dat; fifo_rd = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_ack_drop", 32'(ack), 32'd0);
        check_eq("t6_wr_drop", 32'(fifo_wr), 32'd0);
        do_reset();
        step(1'b0, a);
        check_eq("t6_restart", 32'(a), 32'd1);

        // Randomized traffic with three read rates
        do_reset();
        rq = '0;
        for (int seg = 0; seg < 3; seg++) begin
            thr = (seg == 0) ? 1 : (seg == 1) ? 4 : 7;
            for (int k = 0; k < 200; k++) begin
                rand_stim();
                step($urandom_range(0, 7) < thr, a);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
